// File: rtl/hilo_unit.sv
// HI/LO register stage behind the combinational mdu: holds the multicycle busy window,
// captures {HI,LO} on retirement, services MTHI/MTLO/MFHI/MFLO and flags divide-by-zero.
module hilo_unit #(
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        MUL_C,
  input  logic        DIV_C,
  input  logic [31:0] DIVISOR,
  input  logic [31:0] MDU_HI,
  input  logic [31:0] MDU_LO,
  input  logic        MTHI,
  input  logic        MTLO,
  input  logic [31:0] wdata,
  input  logic        MFHI,
  input  logic        MFLO,
  output logic [31:0] rdata,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic        busy,
  output logic        done,
  output logic        div_zero
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  localparam logic [7:0] MUL_CNT = 8'(MUL_LAT - 1);
  localparam logic [7:0] DIV_CNT = 8'(DIV_LAT - 1);

  logic [0:0] state;
  logic [7:0] cnt;
  logic       accept;
  logic       div_by_zero;

  assign accept      = (state == IDLE) && start && (MUL_C || DIV_C);
  assign div_by_zero = !MUL_C && (DIVISOR == 32'd0);

  // A zero-divisor divide retires immediately from IDLE without touching HI/LO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= 8'd0;
      HI       <= 32'd0;
      LO       <= 32'd0;
      done     <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (div_by_zero) begin
              div_zero <= 1'b1;
              done     <= 1'b1;
            end else begin
              cnt      <= MUL_C ? MUL_CNT : DIV_CNT;
              state    <= BUSY;
              div_zero <= 1'b0;
            end
          end else begin
            if (MTHI) HI <= wdata;
            if (MTLO) LO <= wdata;
          end
        end
        BUSY: begin
          if (cnt != 8'd0) begin
            cnt <= cnt - 8'd1;
          end else begin
            HI    <= MDU_HI;
            LO    <= MDU_LO;
            state <= IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy  = (state == BUSY);
  assign rdata = MFHI ? HI : (MFLO ? LO : 32'd0);

endmodule

// File: doc/hilo_unit.md
Name: hilo_unit

Overview:
HI/LO register stage directly downstream of the combinational mdu. It captures the mdu {HI,LO} result after a configurable multicycle latency and holds it for MFHI/MFLO. It also services MTHI/MTLO and raises busy so the multicycle control FSM stalls while a MULT/MULTU/DIV/DIVU is in flight. Divide-by-zero is detected and flagged, and HI/LO are left unchanged in that case.

Parameters:
MUL_LAT, 4, cycles busy is held for MULT/MULTU (legal range 1..255)
DIV_LAT, 32, cycles busy is held for DIV/DIVU (legal range 1..255)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
start  in  1  single-cycle request to commit an mdu operation
MUL_C  in  1  multiply select, same meaning as the mdu input
DIV_C  in  1  divide select, same meaning as the mdu input
DIVISOR  in  32  divisor operand (mdu B), used only for zero detection
MDU_HI  in  32  mdu HI output
MDU_LO  in  32  mdu LO output
MTHI  in  1  write wdata to HI
MTLO  in  1  write wdata to LO
wdata  in  32  GPR data for MTHI/MTLO
MFHI  in  1  read select HI
MFLO  in  1  read select LO
rdata  out  32  MFHI/MFLO read data
HI  out  32  current HI register
LO  out  32  current LO register
busy  out  1  operation in flight; control FSM must stall
done  out  1  one-cycle pulse when the operation retires
div_zero  out  1  last DIV had divisor 0; sticky until the next accepted start

Behaviour:
- Reset is asynchronous and active-low. Asserting rst_n=0 at any time, including mid-operation, forces state IDLE, HI=0, LO=0, busy=0, done=0, div_zero=0, and cnt=0. Any in-flight result is discarded.
- Two-state FSM: IDLE and BUSY. Internal 8-bit down-counter cnt. busy is 1 exactly when state is BUSY.
- Start is accepted in IDLE when start=1 and (MUL_C or DIV_C) is 1:
  - MUL_C has priority if both selects are set, matching the mdu.
  - Multiply: cnt<=MUL_LAT-1, state goes to BUSY, div_zero<=0.
  - Divide with DIVISOR!=0: cnt<=DIV_LAT-1, state goes to BUSY, div_zero<=0.
  - Divide with DIVISOR==0: stay in IDLE, HI/LO unchanged, div_zero<=1, done<=1 on the next cycle.
  - The operation latches as multiply or divide at this point; MUL_C/DIV_C are ignored afterwards.
- start with neither select set: ignored, no state change.
- In BUSY: if cnt!=0 then cnt<=cnt-1. If cnt==0 then HI<=MDU_HI, LO<=MDU_LO, state goes to IDLE, done<=1.
- Timing: a start accepted at edge k gives busy=1 for exactly LAT cycles. The capture happens at edge k+LAT, and done=1 during the following cycle.
- Upstream must hold the mdu operands stable while busy=1; the control FSM guarantees this by stalling.
- done is registered and high for one cycle only. It is 0 otherwise, including the cycle of a start.
- Accesses during BUSY: start, MTHI, and MTLO are ignored, with no effect on HI/LO or the counter.
- Priority in IDLE: an accepted start wins over MTHI/MTLO in the same cycle, and the MT writes are dropped.
- MTHI/MTLO in IDLE without an accepted start: the register is written at that edge. MTHI and MTLO in the same cycle write both registers with wdata.
- rdata is combinational: MFHI ? HI : (MFLO ? LO : 0). MFHI wins if both are set. rdata reflects the registered values in every state; during BUSY it shows the old values.
- Writes are full 32-bit with no sign handling; all signedness lives in the mdu.

Test Plan:
1. Reset, then MTHI wdata=0x12345678 and MTLO wdata=0x9ABCDEF0 (separate cycles) → HI=0x12345678, LO=0x9ABCDEF0. MFHI gives rdata=0x12345678; MFLO gives 0x9ABCDEF0.
2. start with MUL_C=1, MDU_HI=0xFFFFFFFF, MDU_LO=0xFFFFFFFE (signed -1*2), MUL_LAT=4 → busy high for exactly 4 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFE, and done pulses one cycle.
3. start with DIV_C=1, DIVISOR=0 while HI=0x11, LO=0x22 → busy stays 0, HI/LO unchanged, div_zero=1, done pulses the next cycle. A following valid MUL start clears div_zero.
4. During a DIV_LAT=32 divide, drive MTHI wdata=0xDEAD and a second start on cycle 10 → both are ignored. At retirement HI/LO equal MDU_HI/MDU_LO (e.g. rem 0x3 / quo 0x7), and busy spans exactly 32 cycles.
5. Pull rst_n low asynchronously at cycle 2 of a multiply → HI=LO=0 and busy=done=0 immediately. No capture occurs after release.
6. In IDLE, start with MUL_C=1 and MTLO=1 in the same cycle → the MTLO is dropped and LO takes MDU_LO after MUL_LAT. Separately, MFHI=MFLO=1 → rdata=HI.
